// File: rtl/mdu_iterative_pkg.sv
// Shared definitions for the multiply/divide execute unit.
//   mdu_op_t        : op[3] = 32-bit (W) form, op[2] = divide, op[1:0] = variant
//   mdu_state_t     : sequencer states of the iterative MDU
//   MDU_DIV_ITERS   : radix-2 steps for a 64-bit divide
//   MDU_DIVW_ITERS  : radix-2 steps for a 32-bit divide
//   mdu_mul_iters() : shift-add cycles for a multiply at a given radix
package mdu_iterative_pkg;

  typedef enum logic [3:0] {
    MDU_MUL    = 4'b0000,
    MDU_MULH   = 4'b0001,
    MDU_MULHSU = 4'b0010,
    MDU_MULHU  = 4'b0011,
    MDU_DIV    = 4'b0100,
    MDU_DIVU   = 4'b0101,
    MDU_REM    = 4'b0110,
    MDU_REMU   = 4'b0111,
    MDU_MULW   = 4'b1000,
    MDU_DIVW   = 4'b1100,
    MDU_DIVUW  = 4'b1101,
    MDU_REMW   = 4'b1110,
    MDU_REMUW  = 4'b1111
  } mdu_op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    ITER  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } mdu_state_t;

  localparam int MDU_DIV_ITERS  = 64;
  localparam int MDU_DIVW_ITERS = 32;

  function automatic int mdu_mul_iters(input int bits_per_cycle, input logic is_w);
    return (is_w ? 32 : 64) / bits_per_cycle;
  endfunction

endpackage

// File: rtl/mdu_iterative_if.sv
// Issue / writeback bundle between the issue stage, the MDU and the
// writeback arbiter.
//   master : issue side and writeback consumer (drives issue_*, flush, WB_ready)
//   slave  : the MDU (drives issue_ready, WB_valid, WB_data, WB_PR)
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. A producer holding valid high keeps its payload unchanged
// until that edge; ready may change freely and never depends on valid.
interface mdu_iterative_if #(
  parameter int LOG_PR_COUNT = 7
);
  logic                    issue_valid;
  logic [3:0]              issue_op;
  logic [63:0]             issue_A;
  logic [63:0]             issue_B;
  logic [LOG_PR_COUNT-1:0] issue_dest_PR;
  logic                    issue_ready;
  logic                    flush;
  logic                    WB_valid;
  logic [63:0]             WB_data;
  logic [LOG_PR_COUNT-1:0] WB_PR;
  logic                    WB_ready;

  modport master (
    output issue_valid, issue_op, issue_A, issue_B, issue_dest_PR, flush, WB_ready,
    input  issue_ready, WB_valid, WB_data, WB_PR
  );

  modport slave (
    input  issue_valid, issue_op, issue_A, issue_B, issue_dest_PR, flush, WB_ready,
    output issue_ready, WB_valid, WB_data, WB_PR
  );
endinterface

// File: rtl/mdu_iterative_div_step.sv
// mdu_div_step: one combinational restoring radix-2 division step.
//   rem_in  : current partial remainder (always < divisor)
//   quo_in  : dividend bits still to shift in (MSB first), quotient bits
//             accumulate at the LSB end
//   divisor : divisor magnitude
//   rem_out / quo_out : values after this step
module mdu_div_step (
  input  logic [63:0] rem_in,
  input  logic [63:0] quo_in,
  input  logic [63:0] divisor,
  output logic [63:0] rem_out,
  output logic [63:0] quo_out
);
  logic [64:0] shifted;
  logic [64:0] diff;

  always_comb begin
    shifted = {rem_in, quo_in[63]};
    diff    = shifted - {1'b0, divisor};
    // shifted < 2*divisor, so bit 64 of diff is exactly the borrow.
    if (diff[64]) begin
      rem_out = shifted[63:0];
      quo_out = {quo_in[62:0], 1'b0};
    end else begin
      rem_out = diff[63:0];
      quo_out = {quo_in[62:0], 1'b1};
    end
  end
endmodule

// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle RV64M multiply/divide unit, one op in flight.
//   CLK, nRST : clock, asynchronous active-low reset
//   mdu       : issue/writeback bundle (slave side), including flush
//   dbg_state : current sequencer state
// Optional build macro MDU_DIV_EARLY_OUT_EN: a divide whose dividend magnitude
// is below the divisor magnitude skips the iterations (results unchanged).
module mdu_iterative
  import mdu_iterative_pkg::*;
#(
  parameter int MUL_BITS_PER_CYCLE = 8,
  parameter int LOG_PR_COUNT       = 7
) (
  input  logic               CLK,
  input  logic               nRST,
  mdu_iterative_if.slave     mdu,
  output mdu_state_t         dbg_state
);
  localparam int M = MUL_BITS_PER_CYCLE;

  mdu_state_t              state;
  logic [3:0]              op_q;
  logic [63:0]             a_q, b_q;
  logic [LOG_PR_COUNT-1:0] tag_q;
  logic [6:0]              cnt;
  logic [127:0]            acc, mcand;
  logic [63:0]             mplier, rem, quo, dvsr;
  logic                    neg_q, neg_r;
  logic                    wb_valid_q;
  logic [63:0]             wb_data_q;
  logic [LOG_PR_COUNT-1:0] wb_pr_q;

  // Operand decode of the latched op.
  logic        is_w, is_div, a_signed, b_signed, a_neg, b_neg, dbz, ovf;
  logic [1:0]  var_sel;
  logic [63:0] a_ext, b_ext, mag_a, mag_b;
  logic [6:0]  k_full;

  always_comb begin
    is_w     = op_q[3];
    is_div   = op_q[2];
    var_sel  = op_q[1:0];
    // Only MULH/MULHSU (non-W) and signed divides treat operands as signed.
    a_signed = is_div ? ~var_sel[0] : (~is_w & (var_sel == 2'b01 || var_sel == 2'b10));
    b_signed = is_div ? ~var_sel[0] : (~is_w & (var_sel == 2'b01));
    a_ext    = is_w ? {{32{a_signed & a_q[31]}}, a_q[31:0]} : a_q;
    b_ext    = is_w ? {{32{b_signed & b_q[31]}}, b_q[31:0]} : b_q;
    a_neg    = a_signed & a_ext[63];
    b_neg    = b_signed & b_ext[63];
    mag_a    = a_neg ? (64'd0 - a_ext) : a_ext;
    mag_b    = b_neg ? (64'd0 - b_ext) : b_ext;
    dbz      = is_div & (b_ext == 64'd0);
    ovf      = is_div & ~var_sel[0] & (b_ext == '1) &
               (a_ext == (is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    if (is_div) k_full = is_w ? 7'(MDU_DIVW_ITERS) : 7'(MDU_DIV_ITERS);
    else        k_full = 7'(mdu_mul_iters(M, is_w));
  end

  // Partial product of the low M multiplier bits.
  logic [127:0] pp;
  always_comb begin
    pp = '0;
    for (int i = 0; i < M; i++) begin
      if (mplier[i]) pp = pp + (mcand << i);
    end
  end

  logic [63:0] rem_nxt, quo_nxt;
  mdu_div_step u_div_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (dvsr),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  // Final result selection used in FIXUP.
  logic [127:0] prod;
  logic [63:0]  q_val, r_val, res, res_w;
  always_comb begin
    prod  = neg_q ? (128'd0 - acc) : acc;
    q_val = neg_q ? (64'd0 - quo) : quo;
    r_val = neg_r ? (64'd0 - rem) : rem;
    if (is_div)                        res = var_sel[1] ? r_val : q_val;
    else if (is_w || var_sel == 2'b00) res = prod[63:0];
    else                               res = prod[127:64];
    res_w = is_w ? {{32{res[31]}}, res[31:0]} : res;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      rem        <= '0;
      quo        <= '0;
      dvsr       <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_pr_q    <= '0;
    end else if (mdu.flush) begin
      state      <= IDLE;
      wb_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mdu.issue_valid) begin
            op_q  <= mdu.issue_op;
            a_q   <= mdu.issue_A;
            b_q   <= mdu.issue_B;
            tag_q <= mdu.issue_dest_PR;
            state <= PREP;
          end
        end
        PREP: begin
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          acc    <= '0;
          mcand  <= {64'd0, mag_a};
          mplier <= mag_b;
          rem    <= '0;
          // W divides start with the 32-bit dividend in the top half so the
          // quotient ends up in quo[31:0] after 32 steps.
          quo    <= is_w ? {mag_a[31:0], 32'd0} : mag_a;
          dvsr   <= mag_b;
          if (dbz) begin
            quo   <= '1;
            rem   <= a_ext;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            cnt   <= '0;
            state <= FIXUP;
          end else if (ovf) begin
            quo   <= a_ext;
            rem   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            cnt   <= '0;
            state <= FIXUP;
          end
`ifdef MDU_DIV_EARLY_OUT_EN
          else if (is_div && (mag_a < mag_b)) begin
            // Quotient is zero and the remainder is the dividend itself;
            // neg_r restores the dividend's sign in FIXUP.
            quo   <= '0;
            rem   <= mag_a;
            cnt   <= '0;
            state <= FIXUP;
          end
`endif
          else begin
            cnt   <= k_full;
            state <= ITER;
          end
        end
        ITER: begin
          if (is_div) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
          end else begin
            acc    <= acc + pp;
            mcand  <= mcand << M;
            mplier <= mplier >> M;
          end
          cnt <= cnt - 7'd1;
          if (cnt == 7'd1) state <= FIXUP;
        end
        FIXUP: begin
          wb_data_q  <= res_w;
          wb_pr_q    <= tag_q;
          wb_valid_q <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (mdu.WB_ready) begin
            wb_valid_q <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mdu.issue_ready = (state == IDLE) & ~mdu.flush;
  assign mdu.WB_valid    = wb_valid_q;
  assign mdu.WB_data     = wb_data_q;
  assign mdu.WB_PR       = wb_pr_q;
  assign dbg_state       = state;

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
Multi-cycle multiply/divide execute unit for RV64M.
- Consumes the team's mdu_op_t encodings (MDU_MUL … MDU_REMUW) issued by the decode/issue path.
- Produces a 64-bit writeback tagged with the destination physical register.
- One op in flight at a time, between issue and the writeback arbiter.

Parameters:
MUL_BITS_PER_CYCLE, 8, multiplier bits retired per ITER cycle; legal values 1,2,4,8,16,32.
LOG_PR_COUNT, 7, physical register tag width.

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
issue_valid  input  1  op offered
issue_op  input  4  mdu_op_t
issue_A  input  64  rs1 value
issue_B  input  64  rs2 value
issue_dest_PR  input  LOG_PR_COUNT  destination tag
issue_ready  output  1  unit can accept
flush  input  1  kill in-flight op
WB_valid  output  1  result available
WB_data  output  64  result
WB_PR  output  LOG_PR_COUNT  destination tag
WB_ready  input  1  consumer accepts result

Behaviour:
- Clocking and reset: one clock, CLK. Reset nRST is asynchronous, active-low.
- Reset values: state IDLE, issue_ready=1, WB_valid=0, WB_data=0, WB_PR=0, all internal registers 0.
- Op decode:
  - op[3]=W (32-bit), op[2]=divide, op[1:0] selects variant.
  - Unused codes 1001/1010/1011 execute as MDU_MULW.
- States: IDLE, PREP, ITER, FIXUP, DONE.
  - IDLE: issue_ready = ~flush. On issue_valid & issue_ready: latch op/A/B/tag, go to PREP.
  - PREP (1 cycle): compute operand magnitudes and result sign. Load iteration counter K:
    - mul: 64/MUL_BITS_PER_CYCLE
    - MULW: 32/MUL_BITS_PER_CYCLE
    - div/rem: 64
    - W div/rem: 32
    - Divide-by-zero or signed overflow: K=0, skip ITER and go to FIXUP.
  - ITER (K cycles):
    - mul: shift-add of MUL_BITS_PER_CYCLE multiplier bits per cycle into a 128-bit accumulator.
    - div: one restoring radix-2 step per cycle.
    - Counter decrements each cycle; at 1, go to FIXUP.
  - FIXUP (1 cycle): conditional negate, select high/low/quotient/remainder, sign-extend bit 31 for W ops; go to DONE.
  - DONE: WB_valid=1. On WB_ready go to IDLE.
- issue_ready=0 in every state except IDLE, so there is no accept in the cycle DONE drains.
- Latency: accept at edge 0 gives WB_valid in cycle K+3.
  - MUL (default): 11
  - MULW: 7
  - DIV: 67
  - DIVW: 35
  - divide-by-zero or overflow: 3
- Result rules:
  - MULH/MULHSU/MULHU: upper 64 of the signed×signed / signed×unsigned / unsigned×unsigned product.
  - MUL: lower 64.
  - Divide by zero: quotient = all ones; remainder = dividend (W forms: 32-bit dividend sign-extended).
  - Signed overflow (most negative ÷ −1, 64- or 32-bit per W): quotient = dividend, remainder = 0.
  - Unsigned W forms use zero-extended 32-bit operands; the result is still sign-extended from bit 31.
- Flush:
  - Any state goes to IDLE on the next edge. WB_valid drops the next cycle; no writeback is produced.
  - Flush with WB_valid & WB_ready in the same cycle: the transfer counts as completed.
  - Flush with issue_valid in IDLE: not accepted.
- WB_data and WB_PR stay stable while WB_valid=1 and WB_ready=0.
- Reset asserted mid-op: immediate return to reset values; the op is lost.

Optional Feature:
MDU_DIV_EARLY_OUT_EN
- Defined: in PREP, if |dividend| < |divisor| as unsigned magnitudes (divisor ≠ 0), set K=0. Quotient = 0, remainder = original dividend; latency 3.
- Undefined: every non-exceptional divide runs the full 64/32 iterations.
- Results are identical either way; only latency differs.

Decomposition:
- Shared package already holds mdu_op_t and the MDU_* constants.
- Add to the shared package: MDU_MUL_ITERS/MDU_DIV_ITERS localparam helpers and mdu_state_t enum (IDLE, PREP, ITER, FIXUP, DONE), for reuse by a future pipelined MDU.
- One natural sub-module: mdu_div_step, a combinational restoring-divide step (partial remainder, quotient, divisor in; next values out), instantiated once.

Test Plan:
1. MUL A=0xFFFF_FFFF_FFFF_FFFF (−1), B=3 → WB_data=0xFFFF_FFFF_FFFF_FFFD, WB_valid exactly 11 cycles after accept; MULHU same operands → 0x0000_0000_0000_0002.
2. DIV A=−7, B=2 → 0xFFFF_FFFF_FFFF_FFFD (−3); REM → 0xFFFF_FFFF_FFFF_FFFF (−1); REMU A=7,B=0 → 7; DIVU A=7,B=0 → all ones, latency 3.
3. DIV A=0x8000_0000_0000_0000, B=−1 → 0x8000_0000_0000_0000; REMW A=0x8000_0000, B=0xFFFF_FFFF → 0.
4. MULW A=0x7FFF_FFFF, B=2 → 0xFFFF_FFFF_FFFF_FFFE; DIVUW A=0xFFFF_FFFF, B=1 → 0xFFFF_FFFF_FFFF_FFFF; WB_PR equals issued tag.
5. Hold WB_ready=0 for 5 cycles in DONE → WB_data/WB_PR stable, issue_ready=0. Then assert flush during ITER of a DIV → no WB_valid; next-cycle issue accepted.
6. With MDU_DIV_EARLY_OUT_EN: DIVU A=5, B=9 → quotient 0, latency 3; REMU → 5. Without the macro: same results, latency 67.
